// File: rtl/reg_bus_pkg.sv
// Shared types and CRC helper for the register-bus arbiter.
// crc8 is MSB-first, right-aligned input of nbits bits.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic logic [7:0] crc8(
        input logic [63:0] data,
        input int          nbits
    );
        logic [7:0] c;
        logic       fb;
        c = CRC8_INIT;
        for (int i = 63; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[7] ^ data[i];
                c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_crc8.sv
// Combinational crc8 over an N-bit message, widened/narrowed to CRC_W.
// Used for both the write-request check and the read-return check.
module reg_crc8
    import reg_bus_pkg::*;
#(
    parameter int N     = 16,
    parameter int CRC_W = 8
) (
    input  logic [N-1:0]     i_data,
    output logic [CRC_W-1:0] o_crc
);

    logic [63:0] data_ext;
    logic [7:0]  crc;

    always_comb begin
        data_ext = 64'(i_data);
        crc      = crc8(data_ext, N);
        o_crc    = CRC_W'(crc);
    end

endmodule

// File: rtl/reg_bus_arb.sv
// Two-requester round-robin arbiter onto a CRC-protected register bank.
// One access per IDLE -> ACCESS -> RESP round trip.
module reg_bus_arb
    import reg_bus_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int CRC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_req_vld,
    input  logic [1:0]         i_req_wr,
    input  logic [2*AW-1:0]    i_req_addr,
    input  logic [2*DW-1:0]    i_req_wdata,
    input  logic [2*CRC_W-1:0] i_req_crc,
    output logic [1:0]         o_req_rdy,
    output logic [1:0]         o_rsp_vld,
    output logic [DW-1:0]      o_rsp_rdata,
    output logic               o_rsp_err,
    input  logic [1:0]         i_rsp_rdy,
    output logic               o_wen,
    output logic               o_ren,
    output logic [AW-1:0]      o_addr,
    output logic [DW-1:0]      o_wdata,
    output logic [CRC_W-1:0]   o_crc_data,
    input  logic [DW-1:0]      i_rdata,
    input  logic [CRC_W-1:0]   i_rcrc
);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               cap_wr_q, cap_wr_d;
    logic               cap_idx_q, cap_idx_d;
    logic [AW-1:0]      cap_addr_q, cap_addr_d;
    logic [DW-1:0]      cap_wdata_q, cap_wdata_d;
    logic [CRC_W-1:0]   cap_crc_q, cap_crc_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               gnt_idx;
    logic [1:0]         gnt_oh;
    logic               wr_ok;
    logic [CRC_W-1:0]   wcrc_calc;
    logic [CRC_W-1:0]   rcrc_calc;

    reg_crc8 #(.N(AW + DW), .CRC_W(CRC_W)) u_wcrc (
        .i_data ({cap_addr_q, cap_wdata_q}),
        .o_crc  (wcrc_calc)
    );

    reg_crc8 #(.N(AW + DW), .CRC_W(CRC_W)) u_rcrc (
        .i_data ({cap_addr_q, i_rdata}),
        .o_crc  (rcrc_calc)
    );

    assign wr_ok = (wcrc_calc == cap_crc_q);

    // With both valid, the one not granted last wins.
    always_comb begin
        gnt_idx = (i_req_vld == 2'b11) ? ~last_q : i_req_vld[1];
        gnt_oh  = gnt_idx ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cap_wr_d    = cap_wr_q;
        cap_idx_d   = cap_idx_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_crc_d   = cap_crc_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        o_req_rdy   = 2'b00;
        o_rsp_vld   = 2'b00;
        o_rsp_rdata = '0;
        o_rsp_err   = 1'b0;
        o_wen       = 1'b0;
        o_ren       = 1'b0;
        o_addr      = '0;
        o_wdata     = '0;
        o_crc_data  = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Reset gating keeps rdy low while reset is held.
                o_req_rdy = (gnt_oh & i_req_vld) & {2{i_rst_n}};
                if (|o_req_rdy) begin
                    state_d     = ST_ACCESS;
                    last_d      = gnt_idx;
                    cap_idx_d   = gnt_idx;
                    cap_wr_d    = gnt_idx ? i_req_wr[1] : i_req_wr[0];
                    cap_addr_d  = gnt_idx ? i_req_addr[2*AW-1:AW]
                                          : i_req_addr[AW-1:0];
                    cap_wdata_d = gnt_idx ? i_req_wdata[2*DW-1:DW]
                                          : i_req_wdata[DW-1:0];
                    cap_crc_d   = gnt_idx ? i_req_crc[2*CRC_W-1:CRC_W]
                                          : i_req_crc[CRC_W-1:0];
                end
            end
            ST_ACCESS: begin
                o_addr     = cap_addr_q;
                o_wdata    = cap_wdata_q;
                o_crc_data = cap_crc_q;
                o_wen      = cap_wr_q & wr_ok;
                o_ren      = ~cap_wr_q;
                rdata_d    = cap_wr_q ? '0 : i_rdata;
                err_d      = cap_wr_q ? ~wr_ok : (i_rcrc != rcrc_calc);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_vld   = cap_idx_q ? 2'b10 : 2'b01;
                o_rsp_rdata = rdata_q;
                o_rsp_err   = err_q;
                if (i_rsp_rdy[cap_idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            cap_wr_q    <= 1'b0;
            cap_idx_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_crc_q   <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cap_wr_q    <= cap_wr_d;
            cap_idx_q   <= cap_idx_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_crc_q   <= cap_crc_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/reg_bus_arb.md
REG_BUS_ARB -- requirements
Module: reg_bus_arb

Interface
REQ-001 Parameters SHALL be: DW, default 8, register data width; AW, default 8, register address width; CRC_W, default 8, CRC width.
REQ-002 Ports SHALL be, in this order:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_vld  in  2  per-requester request valid; bit 0 = SPI host, bit 1 = internal scanner.
- i_req_wr  in  2  per-requester 1 = write, 0 = read.
- i_req_addr  in  2xAW  per-requester address.
- i_req_wdata  in  2xDW  per-requester write data.
- i_req_crc  in  2xCRC_W  per-requester write CRC.
- o_req_rdy  out  2  per-requester request accept.
- o_rsp_vld  out  2  per-requester response valid.
- o_rsp_rdata  out  DW  response read data, shared.
- o_rsp_err  out  1  response error flag, shared.
- i_rsp_rdy  in  2  per-requester response accept.
- o_wen  out  1  register-bank write strobe.
- o_ren  out  1  register-bank read strobe.
- o_addr  out  AW  register-bank address.
- o_wdata  out  DW  register-bank write data.
- o_crc_data  out  CRC_W  register-bank stored CRC.
- i_rdata  in  DW  ORed bank read data, combinational to o_ren.
- i_rcrc  in  CRC_W  ORed bank read CRC, combinational to o_ren.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS and RESP; reset state IDLE.
REQ-004 In IDLE, o_req_rdy SHALL be 1 only for the granted requester and only when its i_req_vld=1; handshake = vld & rdy; transition to ACCESS.
REQ-005 Arbitration SHALL be round-robin on a 1-bit last-grant pointer.
- Both valid: grant the requester not last granted.
- Pointer resets to 1, so requester 0 wins first.
- Pointer updates only on handshake.
REQ-006 On handshake, wr, addr, wdata and crc SHALL be captured into internal registers, together with the requester index.
REQ-007 In ACCESS, for exactly one cycle:
- o_addr, o_wdata and o_crc_data SHALL drive the captured values.
- o_wen SHALL be 1 for a write, o_ren SHALL be 1 for a read; never both.
- Next state SHALL be RESP.
REQ-008 Write CRC check: crc8 SHALL be computed over {addr,wdata} (polynomial 0x07, init 0x00, MSB first).
- On mismatch, o_wen SHALL stay 0 in ACCESS and the error flag SHALL be set.
REQ-009 Read CRC check: in ACCESS, i_rdata SHALL be registered.
- The error flag SHALL be set if i_rcrc != crc8({addr,i_rdata}); this includes reads returning zeros from a mode-gated register.
REQ-010 In RESP:
- o_rsp_vld SHALL be 1 only for the captured requester.
- o_rsp_rdata SHALL be 0 for writes and the registered read data for reads.
- o_rsp_err SHALL drive the error flag.
- State SHALL hold until i_rsp_rdy of that requester is 1, then go to IDLE.
REQ-011 Latency SHALL be: handshake in cycle k, bank strobe in k+1, o_rsp_vld from k+2. Back-to-back requests SHALL therefore see at most one accepted request per 3 cycles.
REQ-012 Outside ACCESS, o_wen, o_ren, o_addr, o_wdata and o_crc_data SHALL be 0. Outside RESP, o_rsp_vld, o_rsp_rdata and o_rsp_err SHALL be 0.
REQ-013 Requests SHALL wait, with o_req_rdy=0, while state != IDLE; i_req_vld dropping before handshake SHALL be legal and no access SHALL occur.
REQ-014 Response data SHALL remain stable while o_rsp_vld=1 and i_rsp_rdy=0.

Reset
REQ-015 Asserting i_rst_n low at any time, including mid-ACCESS or mid-RESP, SHALL immediately force:
- state IDLE, all outputs 0, pointer 1, all capture registers 0.
REQ-016 A request pending across reset SHALL be discarded; no bank strobe SHALL be issued for it.

Structure
REQ-017 Package reg_bus_pkg SHALL hold the FSM state enum, the crc8 function and the CRC polynomial/init constants.
REQ-018 The crc8 computation SHALL be one sub-module, reg_crc8, instanced twice: write check and read check.

Verification
REQ-019 Write, requester 0: addr 0x12, wdata 0xA5, correct crc -> o_wen pulse at k+1 with o_addr 0x12, o_wdata 0xA5; rsp_vld[0] at k+2, err 0, rdata 0.
REQ-020 Bad write CRC: same write with crc XOR 0x01 -> o_wen stays 0; rsp_err 1.
REQ-021 Read: addr 0x12, bank returns 0xA5 plus matching crc -> o_ren pulse at k+1; rsp_rdata 0xA5, err 0. Bank returns 0x00/0x00 -> err 1.
REQ-022 Contention: both requesters valid continuously for 4 transactions -> grants 0,1,0,1; each response goes only to its owner.
REQ-023 Backpressure: i_rsp_rdy[1]=0 for 5 cycles -> response held stable; requester 0 rdy stays 0 until release.
REQ-024 Reset in ACCESS cycle -> o_wen/o_ren drop to 0 immediately; after release, requester 0 wins the first simultaneous request.
